fb_access_arbiter: RTL and testbench

//  Shares the single-port frame RAM (RAM_sync, 20b addr {x,y}, 12b RGB444) between the VGA

---
 rtl/fb_access_arbiter_pkg.sv | 32 +++
 rtl/fb_access_arbiter_if.sv | 30 +++
 rtl/fb_access_arbiter_write_fifo.sv | 80 ++++++++
 rtl/fb_access_arbiter.sv | 123 ++++++++++++
 tb/tb_fb_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_access_arbiter_pkg.sv
// Shared definitions for the frame-buffer access arbiter.
// Holds the coordinate/pixel/address widths, default visible-area limits,
// the arbiter state encoding, the buffered write-entry layout and the
// helper that packs a pixel coordinate into a frame RAM address.
package fb_access_arbiter_pkg;

    localparam int COORD_W      = 10;
    localparam int PIX_W        = 12;
    localparam int ADDR_W       = 20;
    localparam int ENTRY_W      = 2 * COORD_W + PIX_W;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic {
        S_DISP  = 1'b0,
        S_DRAIN = 1'b1
    } arb_state_e;

    // One buffered write request, 32 bits wide: {x, y, colour}.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [PIX_W-1:0]   data;
    } wr_entry_t;

    // The frame RAM is addressed column-major as {x, y}.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Draw-side write port of the frame-buffer arbiter.
// Signals:
//   wr_valid  writer -> arbiter  request present
//   wr_ready  arbiter -> writer  write buffer can take an entry
//   wr_x      writer -> arbiter  target column
//   wr_y      writer -> arbiter  target row
//   wr_data   writer -> arbiter  colour {R,G,B}
//   wr_drop   arbiter -> writer  1-cycle pulse, a popped entry was out of range
// Modports: master = the drawing client, slave = the arbiter.
interface fb_access_arbiter_if;
    import fb_access_arbiter_pkg::*;

    logic               wr_valid;
    logic               wr_ready;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [PIX_W-1:0]   wr_data;
    logic               wr_drop;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready, wr_drop
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready, wr_drop
    );

endinterface

// File: rtl/fb_access_arbiter_write_fifo.sv
// Synchronous write-request buffer for the frame-buffer arbiter.
// Ports:
//   clk_d, rst     pixel clock, synchronous active-high reset
//   push, din      enqueue an entry (ignored when full)
//   pop, dout      dequeue the head entry (ignored when empty); dout is the head
//   full, empty    occupancy flags
//   count          number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fb_write_fifo
    import fb_access_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_d,
    input  logic                       rst,
    input  logic                       push,
    input  wr_entry_t                  din,
    input  logic                       pop,
    output wr_entry_t                  dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    wr_entry_t        mem_q [DEPTH];
    wr_entry_t        mem_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A push while full is refused even if a pop happens the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: an empty FIFO never exposes a stale entry.
    always_ff @(posedge clk_d) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter.
// Shares the single-port frame RAM between the VGA pixel fetch and one draw-side
// writer. While video_on is high the display owns the RAM every cycle; writer
// requests wait in a small FIFO and are drained only during blanking.
// Ports:
//   clk_d, rst           pixel clock, synchronous active-high reset
//   x_loc, y_loc         current display coordinate
//   video_on             1 in the visible region
//   red, green, blue     registered display colour, 0 while blanked
//   wr_if                draw-side write port (slave side)
//   ram_addr/din/we      frame RAM request, address {x,y}
//   ram_dout             frame RAM read data, one cycle after ram_addr
module fb_access_arbiter
    import fb_access_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
    input  logic               clk_d,
    input  logic               rst,
    input  logic [COORD_W-1:0] x_loc,
    input  logic [COORD_W-1:0] y_loc,
    input  logic               video_on,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    fb_access_arbiter_if.slave wr_if,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [PIX_W-1:0]   ram_din,
    output logic               ram_we,
    input  logic [PIX_W-1:0]   ram_dout
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_e       state_q, state_d;
    logic             vo_q, vo_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;

    wr_entry_t        push_entry;
    wr_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             head_in_range;

    assign push_entry = '{x: wr_if.wr_x, y: wr_if.wr_y, data: wr_if.wr_data};

    // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
    assign wr_if.wr_ready = !fifo_full && !rst;
    assign push           = wr_if.wr_valid && wr_if.wr_ready;

    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_write_fifo (
        .clk_d (clk_d),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_in_range = (32'(head.x) < 32'(H_ACTIVE)) && (32'(head.y) < 32'(V_ACTIVE));

    // video_on overrides a drain in the very same cycle, so the display read is
    // never displaced; rst gates the in-flight write the cycle it is sampled.
    assign pop           = (state_q == S_DRAIN) && !video_on && !fifo_empty && !rst;

    assign ram_we        = pop && head_in_range;
    assign wr_if.wr_drop = pop && !head_in_range;
    assign ram_din       = head.data;
    assign ram_addr      = ram_we ? pack_addr(head.x, head.y) : pack_addr(x_loc, y_loc);

    // Leave the drain as soon as the display returns or the buffer runs dry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DISP: begin
                if (!video_on && !fifo_empty) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (video_on || fifo_empty ||
                    (pop && !push && fifo_count == CNT_W'(1))) begin
                    state_d = S_DISP;
                end
            end
            default: state_d = S_DISP;
        endcase
    end

    // The RAM answers one cycle after the address, so video_on is delayed one
    // cycle to line up with ram_dout and the colour register adds the second.
    always_comb begin
        vo_d  = video_on;
        rgb_d = vo_q ? ram_dout : '0;
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_q <= S_DISP;
            vo_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            vo_q    <= vo_d;
            rgb_q   <= rgb_d;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter.
// A behavioural RAM_sync sits on the RAM side. A reference model built from the
// arbitration rules (queue of accepted writes, two-cycle display latency, drains
// only after two consecutive blank cycles with pending data) is compared against
// the DUT on every negative clock edge; directed scenarios add literal checks.
module tb_fb_access_arbiter;
    import fb_access_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int HMAX  = 640;
    localparam int VMAX  = 480;

    logic        clk_d = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x_loc = '0;
    logic [9:0]  y_loc = '0;
    logic        video_on = 1'b0;
    logic [3:0]  red, green, blue;
    logic [19:0] ram_addr;
    logic [11:0] ram_din;
    logic        ram_we;
    logic [11:0] ram_dout = '0;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk_d = ~clk_d;

    fb_access_arbiter_if wr_bus ();

    fb_access_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .H_ACTIVE   (HMAX),
        .V_ACTIVE   (VMAX)
    ) dut (
        .clk_d    (clk_d),
        .rst      (rst),
        .x_loc    (x_loc),
        .y_loc    (y_loc),
        .video_on (video_on),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .wr_if    (wr_bus.slave),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    // Behavioural RAM_sync: read-first, one cycle of read latency.
    logic [11:0] ram_mem [logic [19:0]];

    always @(posedge clk_d) begin
        ram_dout <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 12'h000;
        if (ram_we) begin
            ram_mem[ram_addr] = ram_din;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state.
    logic [11:0] model_mem [logic [19:0]];
    wr_entry_t   model_q [$];
    bit          prev_pending = 1'b0;
    bit          rst_h1 = 1'b1, rst_h2 = 1'b1;
    bit          vo_h1 = 1'b0, vo_h2 = 1'b0;
    logic [11:0] val_h1 = '0, val_h2 = '0;

    // Per-cycle compare against the model, then advance the model by one cycle.
    always @(negedge clk_d) begin : compare_proc
        int          cnt;
        bit          exp_ready;
        bit          exp_pop;
        bit          in_rng;
        bit          pushed;
        wr_entry_t   hd;
        logic [11:0] exp_rgb;
        logic [11:0] cur_val;
        logic [19:0] disp_addr;

        cnt       = model_q.size();
        disp_addr = {x_loc, y_loc};
        exp_ready = !rst && (cnt < DEPTH);
        checkOutput("wr_ready", {31'd0, wr_bus.wr_ready}, {31'd0, exp_ready});

        exp_pop = !rst && !video_on && prev_pending && (cnt > 0);
        in_rng  = 1'b0;
        hd      = '0;
        if (exp_pop) begin
            hd     = model_q[0];
            in_rng = (int'(hd.x) < HMAX) && (int'(hd.y) < VMAX);
        end
        checkOutput("ram_we", {31'd0, ram_we}, {31'd0, exp_pop && in_rng});
        checkOutput("wr_drop", {31'd0, wr_bus.wr_drop}, {31'd0, exp_pop && !in_rng});
        if (exp_pop && in_rng) begin
            checkOutput("wr_addr", {12'd0, ram_addr}, {12'd0, hd.x, hd.y});
            checkOutput("wr_din", {20'd0, ram_din}, {20'd0, hd.data});
            model_mem[{hd.x, hd.y}] = hd.data;
        end else if (!exp_pop) begin
            checkOutput("disp_addr", {12'd0, ram_addr}, {12'd0, disp_addr});
        end

        exp_rgb = (!rst_h1 && !rst_h2 && vo_h2) ? val_h2 : 12'h000;
        checkOutput("rgb", {20'd0, red, green, blue}, {20'd0, exp_rgb});

        cur_val = model_mem.exists(disp_addr) ? model_mem[disp_addr] : 12'h000;
        rst_h2  = rst_h1;
        rst_h1  = rst;
        vo_h2   = vo_h1;
        vo_h1   = video_on;
        val_h2  = val_h1;
        val_h1  = cur_val;

        pushed       = wr_bus.wr_valid && exp_ready;
        prev_pending = !video_on && !rst && (cnt > 0);
        if (rst) begin
            model_q.delete();
        end else begin
            if (exp_pop) begin
                void'(model_q.pop_front());
            end
            if (pushed) begin
                model_q.push_back('{x: wr_bus.wr_x, y: wr_bus.wr_y, data: wr_bus.wr_data});
            end
        end
    end

    // One cycle of stimulus; returns at the following negative edge.
    task automatic applyStimulus(input bit r, input bit vo, input logic [9:0] x,
                                 input logic [9:0] y, input bit wv, input logic [9:0] wx,
                                 input logic [9:0] wy, input logic [11:0] wd);
        @(posedge clk_d);
        #1;
        rst             = r;
        video_on        = vo;
        x_loc           = x;
        y_loc           = y;
        wr_bus.wr_valid = wv;
        wr_bus.wr_x     = wx;
        wr_bus.wr_y     = wy;
        wr_bus.wr_data  = wd;
        @(negedge clk_d);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [6:0] pat7;
        logic [3:0] pat4;
        logic [2:0] pat3;
        int         nwe;
        int         ndrop;

        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_x     = '0;
        wr_bus.wr_y     = '0;
        wr_bus.wr_data  = '0;
        ram_mem[{10'd10, 10'd20}]   = 12'hA5C;
        model_mem[{10'd10, 10'd20}] = 12'hA5C;

        // Reset held three cycles, then released.
        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rgb", {20'd0, red, green, blue}, 32'h0);
        checkOutput("t1_ram_we", {31'd0, ram_we}, 32'h0);
        checkOutput("t1_ready_in_rst", {31'd0, wr_bus.wr_ready}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_ready_after", {31'd0, wr_bus.wr_ready}, 32'h1);

        // Display read latency.
        $display("[TB] display latency");
        applyStimulus(0, 1, 10, 20, 0, 0, 0, 0);
        applyStimulus(0, 1, 11, 20, 0, 0, 0, 0);
        applyStimulus(0, 1, 12, 20, 0, 0, 0, 0);
        checkOutput("t2_rgb", {20'd0, red, green, blue}, 32'hA5C);

        // Fill the buffer while visible, then drain in blanking.
        $display("[TB] fill and drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 10'(i), 0, 1, 10'(100 + i), 10'd50, 12'(12'h100 + i));
        applyStimulus(0, 1, 4, 0, 0, 0, 0, 0);
        checkOutput("t3_full", {31'd0, wr_bus.wr_ready}, 32'h0);
        checkOutput("t3_no_we_visible", {31'd0, ram_we}, 32'h0);
        pat7 = '0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            pat7[i] = ram_we;
        end
        checkOutput("t3_we_pattern", {25'd0, pat7}, 32'h1E);
        checkOutput("t3_ready_after", {31'd0, wr_bus.wr_ready}, 32'h1);

        // Partial drain interrupted by the display.
        $display("[TB] interrupted drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, 0, 1, 10'(200 + i), 10'(300 + i), 12'(12'h200 + i));
        pat3 = '0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            pat3[i] = ram_we;
        end
        checkOutput("t4_first_pattern", {29'd0, pat3}, 32'h6);
        applyStimulus(0, 1, 5, 5, 0, 0, 0, 0);
        checkOutput("t4_vo_override", {31'd0, ram_we}, 32'h0);
        applyStimulus(0, 1, 6, 5, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 5, 0, 0, 0, 0);
        pat4 = '0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            pat4[i] = ram_we;
        end
        checkOutput("t4_second_pattern", {28'd0, pat4}, 32'h6);

        // Out-of-range entry is dropped; the edge pixel is written.
        $display("[TB] range limits");
        applyStimulus(0, 0, 0, 0, 1, 10'd640, 10'd5, 12'hFFF);
        nwe   = 0;
        ndrop = int'(wr_bus.wr_drop);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            ndrop += int'(wr_bus.wr_drop);
            nwe   += int'(ram_we);
        end
        checkOutput("t5_drop_count", ndrop, 1);
        checkOutput("t5_drop_no_we", nwe, 0);
        applyStimulus(0, 0, 0, 0, 1, 10'd639, 10'd479, 12'h123);
        nwe = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            nwe += int'(ram_we);
        end
        checkOutput("t5_edge_written", nwe, 1);
        applyStimulus(0, 1, 639, 479, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("t5_edge_rgb", {20'd0, red, green, blue}, 32'h123);

        // Reset in the middle of a drain.
        $display("[TB] reset during drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, 0, 1, 10'(400 + i), 10'(10 + i), 12'(12'h300 + i));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_one_written", {31'd0, ram_we}, 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_we_in_rst", {31'd0, ram_we}, 32'h0);
        nwe = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            nwe += int'(ram_we);
            if (i == 0) checkOutput("t6_rgb_after_rst", {20'd0, red, green, blue}, 32'h0);
        end
        checkOutput("t6_no_more_we", nwe, 0);
        checkOutput("t6_ready_empty", {31'd0, wr_bus.wr_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
